// File: rtl/vid_yuv2rgb.sv
// BT.601 Y/Cb/Cr to 8-bit RGB converter with a 3-stage pixel-advanced pipeline.
// The sync and blank signals travel alongside the pixel data, so they keep the same delay.
`timescale 1ns/1ps
module vid_yuv2rgb #(
    parameter int FRAC    = 8,
    parameter bit BLANK_Z = 1'b1
) (
    input  logic       CLK,
    input  logic       RESn,
    input  logic       CE,
    input  logic       BYPASS,
    input  logic       PCE_I,
    input  logic [7:0] Y_I,
    input  logic [7:0] U_I,
    input  logic [7:0] V_I,
    input  logic       HSn_I,
    input  logic       VSn_I,
    input  logic       HBL_I,
    input  logic       VBL_I,
    output logic       PCE_O,
    output logic [7:0] R_O,
    output logic [7:0] G_O,
    output logic [7:0] B_O,
    output logic       HS_O,
    output logic       VS_O,
    output logic       HBL_O,
    output logic       VBL_O
);

    localparam logic signed [19:0] RND = 20'sd1 <<< (FRAC - 1);

    function automatic logic signed [17:0] sx9(input logic signed [8:0] d);
        return {{9{d[8]}}, d};
    endfunction

    function automatic logic signed [19:0] sx18(input logic signed [17:0] p);
        return {{2{p[17]}}, p};
    endfunction

    function automatic logic [7:0] clamp8(input logic signed [19:0] x);
        logic signed [19:0] s;
        s = x >>> FRAC;
        if (s[19])             return 8'h00;
        else if (s > 20'sd255) return 8'hff;
        else                   return s[7:0];
    endfunction

    logic adv;
    assign adv = CE & PCE_I;

    // stage 1: offset removal, sync inversion
    logic              s1_byp, s1_hs, s1_vs, s1_hbl, s1_vbl;
    logic [7:0]        s1_y;
    logic signed [8:0] s1_ud, s1_vd;

    // stage 2: products
    logic               s2_byp, s2_hs, s2_vs, s2_hbl, s2_vbl;
    logic [15:0]        s2_y;
    logic [7:0]         s2_u, s2_v;
    logic signed [17:0] s2_pr, s2_pgu, s2_pgv, s2_pb;

    always_ff @(posedge CLK) begin
        if (!RESn) begin
            s1_byp <= 1'b0; s1_hs <= 1'b0; s1_vs <= 1'b0; s1_hbl <= 1'b0; s1_vbl <= 1'b0;
            s1_y   <= '0;   s1_ud <= '0;   s1_vd <= '0;
        end else if (adv) begin
            s1_byp <= BYPASS;
            s1_hs  <= ~HSn_I;
            s1_vs  <= ~VSn_I;
            s1_hbl <= HBL_I;
            s1_vbl <= VBL_I;
            s1_y   <= Y_I;
            s1_ud  <= $signed({1'b0, U_I}) - 9'sd128;
            s1_vd  <= $signed({1'b0, V_I}) - 9'sd128;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESn) begin
            s2_byp <= 1'b0; s2_hs <= 1'b0; s2_vs <= 1'b0; s2_hbl <= 1'b0; s2_vbl <= 1'b0;
            s2_y   <= '0;   s2_u  <= '0;   s2_v  <= '0;
            s2_pr  <= '0;   s2_pgu <= '0;  s2_pgv <= '0;  s2_pb <= '0;
        end else if (adv) begin
            s2_byp <= s1_byp;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
            s2_hbl <= s1_hbl;
            s2_vbl <= s1_vbl;
            s2_y   <= 16'({8'h00, s1_y} << FRAC);
            // raw U/V for bypass: flipping bit 7 undoes the -128 offset
            s2_u   <= s1_ud[7:0] ^ 8'h80;
            s2_v   <= s1_vd[7:0] ^ 8'h80;
            s2_pr  <= sx9(s1_vd) * 18'sd359;
            s2_pgu <= sx9(s1_ud) * 18'sd88;
            s2_pgv <= sx9(s1_vd) * 18'sd183;
            s2_pb  <= sx9(s1_ud) * 18'sd454;
        end
    end

    // stage 3: sum, round, clamp, bypass and blank select
    logic signed [19:0] y_w, r_sum, g_sum, b_sum;
    logic [7:0]         r_nx, g_nx, b_nx;

    always_comb begin
        y_w   = $signed({4'b0000, s2_y});
        r_sum = y_w + sx18(s2_pr) + RND;
        g_sum = y_w - sx18(s2_pgu) - sx18(s2_pgv) + RND;
        b_sum = y_w + sx18(s2_pb) + RND;
        r_nx  = clamp8(r_sum);
        g_nx  = clamp8(g_sum);
        b_nx  = clamp8(b_sum);
        if (s2_byp) begin
            r_nx = s2_u;
            g_nx = s2_y[15:8];
            b_nx = s2_v;
        end
        if (BLANK_Z && (s2_hbl || s2_vbl)) begin
            r_nx = 8'h00;
            g_nx = 8'h00;
            b_nx = 8'h00;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESn) begin
            PCE_O <= 1'b0;
            R_O   <= '0; G_O <= '0; B_O <= '0;
            HS_O  <= 1'b0; VS_O <= 1'b0; HBL_O <= 1'b0; VBL_O <= 1'b0;
        end else begin
            PCE_O <= adv;
            if (adv) begin
                R_O   <= r_nx;
                G_O   <= g_nx;
                B_O   <= b_nx;
                HS_O  <= s2_hs;
                VS_O  <= s2_vs;
                HBL_O <= s2_hbl;
                VBL_O <= s2_vbl;
            end
        end
    end

endmodule

// File: tb/tb_vid_yuv2rgb.sv
// Scoreboard bench for vid_yuv2rgb: the stimulus pushes reference results, and the
// monitor pops one result per PCE_O and checks that the outputs hold between pixels.
`timescale 1ns/1ps
module tb_vid_yuv2rgb;

    logic       CLK = 1'b0, RESn = 1'b0, CE = 1'b0, BYPASS = 1'b0, PCE_I = 1'b0;
    logic [7:0] Y_I = '0, U_I = '0, V_I = '0;
    logic       HSn_I = 1'b1, VSn_I = 1'b1, HBL_I = 1'b0, VBL_I = 1'b0;
    logic       PCE_O, HS_O, VS_O, HBL_O, VBL_O;
    logic [7:0] R_O, G_O, B_O;

    vid_yuv2rgb dut (
        .CLK(CLK), .RESn(RESn), .CE(CE), .BYPASS(BYPASS), .PCE_I(PCE_I),
        .Y_I(Y_I), .U_I(U_I), .V_I(V_I), .HSn_I(HSn_I), .VSn_I(VSn_I),
        .HBL_I(HBL_I), .VBL_I(VBL_I), .PCE_O(PCE_O), .R_O(R_O), .G_O(G_O),
        .B_O(B_O), .HS_O(HS_O), .VS_O(VS_O), .HBL_O(HBL_O), .VBL_O(VBL_O)
    );

    always #5 CLK = ~CLK;

    int checks = 0, errors = 0;
    logic [27:0] exp_q[$];
    logic        mon_en = 1'b0, acc_prev = 1'b0, rst_prev = 1'b0;
    logic [27:0] last = '0;

    function automatic int clampi(int x);
        if (x < 0) return 0;
        if (x > 255) return 255;
        return x;
    endfunction

    // reference: BT.601 integer matrix with rounding, then bypass and blanking
    function automatic logic [27:0] model(int y, int u, int v, bit byp, bit hsn, bit vsn,
                                          bit hbl, bit vbl);
        int r, g, b;
        logic [7:0] r8, g8, b8;
        r = clampi((y * 256 + 359 * (v - 128) + 128) >>> 8);
        g = clampi((y * 256 - 88 * (u - 128) - 183 * (v - 128) + 128) >>> 8);
        b = clampi((y * 256 + 454 * (u - 128) + 128) >>> 8);
        if (byp) begin r = u; g = y; b = v; end
        if (hbl || vbl) begin r = 0; g = 0; b = 0; end
        r8 = 8'(r); g8 = 8'(g); b8 = 8'(b);
        return {r8, g8, b8, ~hsn, ~vsn, hbl, vbl};
    endfunction

    task automatic pixel(int y, int u, int v, bit byp, bit hsn, bit vsn, bit hbl, bit vbl);
        Y_I = 8'(y); U_I = 8'(u); V_I = 8'(v); BYPASS = byp;
        HSn_I = hsn; VSn_I = vsn; HBL_I = hbl; VBL_I = vbl;
        CE = 1'b1; PCE_I = 1'b1;
        exp_q.push_back(model(y, u, v, byp, hsn, vsn, hbl, vbl));
        @(posedge CLK); #1;
        PCE_I = 1'b0;
    endtask

    task automatic idle(int n, bit ce_off);
        CE = ~ce_off; PCE_I = ce_off;
        Y_I = 8'($urandom); U_I = 8'($urandom); V_I = 8'($urandom);
        HSn_I = 1'($urandom); HBL_I = 1'($urandom);
        repeat (n) begin @(posedge CLK); #1; end
        CE = 1'b1; PCE_I = 1'b0;
    endtask

    // two zeroed stages drain out ahead of the first pixel accepted after reset
    task automatic do_reset();
        RESn = 1'b0; CE = 1'b0; PCE_I = 1'b1;
        @(posedge CLK); #1;
        RESn = 1'b1; PCE_I = 1'b0; CE = 1'b1;
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
    endtask

    always @(posedge CLK) begin
        acc_prev <= CE & PCE_I & RESn;
        rst_prev <= ~RESn;
    end

    always @(negedge CLK) begin
        logic [27:0] obs, e;
        obs = {R_O, G_O, B_O, HS_O, VS_O, HBL_O, VBL_O};
        if (mon_en) begin
            checks++;
            if (PCE_O !== acc_prev) begin
                errors++;
                $display("FAIL pce_o: got %b want %b at %0t", PCE_O, acc_prev, $time);
            end
            if (rst_prev) begin
                checks++;
                if (obs !== '0 || PCE_O !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_clear: got %h want 0 at %0t", obs, $time);
                end
            end else if (PCE_O === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pixel_unexpected: got %h with empty queue at %0t", obs, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        errors++;
                        $display("FAIL pixel: got rgb=%h,%h,%h s=%b want rgb=%h,%h,%h s=%b at %0t",
                                 obs[27:20], obs[19:12], obs[11:4], obs[3:0],
                                 e[27:20], e[19:12], e[11:4], e[3:0], $time);
                    end
                end
            end else begin
                checks++;
                if (obs !== last) begin
                    errors++;
                    $display("FAIL hold: got %h want %h at %0t", obs, last, $time);
                end
            end
        end
        last = obs;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        mon_en = 1'b1;
        do_reset();
        // mid-grey, one pixel every second clock
        for (int i = 0; i < 4; i++) begin pixel(128, 128, 128, 0, 1, 1, 0, 0); idle(1, 0); end
        pixel(255, 128, 255, 0, 1, 1, 0, 0);
        pixel(0, 0, 128, 0, 0, 1, 0, 0);
        pixel(200, 128, 128, 0, 1, 0, 1, 0);
        pixel(200, 90, 170, 0, 1, 1, 0, 1);
        pixel('h11, 'h22, 'h33, 1, 1, 1, 0, 0);
        pixel('h11, 'h22, 'h33, 0, 1, 1, 0, 0);
        pixel('h44, 'hee, 'h05, 1, 0, 0, 0, 0);
        pixel(0, 255, 0, 0, 1, 1, 0, 0);
        pixel(255, 0, 255, 0, 1, 1, 0, 0);
        idle(10, 0);
        pixel(77, 33, 222, 0, 1, 1, 0, 0);
        idle(10, 1);
        pixel(10, 240, 20, 0, 1, 1, 0, 0);
        pixel(99, 99, 99, 0, 1, 1, 0, 0);
        do_reset();
        for (int i = 0; i < 400; i++) begin
            pixel($urandom_range(255), $urandom_range(255), $urandom_range(255),
                  ($urandom_range(7) == 0), 1'($urandom), 1'($urandom),
                  ($urandom_range(5) == 0), ($urandom_range(9) == 0));
            if ($urandom_range(3) == 0) idle($urandom_range(4, 1), 1'($urandom));
            if (i == 200) do_reset();
        end
        pixel(0, 128, 128, 0, 1, 1, 0, 0);
        pixel(0, 128, 128, 0, 1, 1, 0, 0);
        idle(3, 0);
        checks++;
        if (exp_q.size() != 2) begin
            errors++;
            $display("FAIL queue_drain: got %0d entries want 2", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
